// File: rtl/fb_scan_reader.sv
// fb_scan_reader: double-buffered framebuffer scan-out engine.
// Raster counters, linear read pointer and a 2-stage pixel/sync pipeline.
module fb_scan_reader #(
  parameter int PIX_W    = 8,
  parameter int ADDR_W   = 20,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              en,
  input  logic              swap_req,
  input  logic [PIX_W-1:0]  rd_data,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [PIX_W-1:0]  pix_out,
  output logic              de,
  output logic              hsync,
  output logic              vsync,
  output logic              frame_start,
  output logic              bank,
  output logic              swap_ack
);

  localparam int HT  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int VT  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW  = $clog2(HT);
  localparam int VW  = $clog2(VT);
  localparam int HS0 = H_ACTIVE + H_FP;
  localparam int HS1 = HS0 + H_SYNC;
  localparam int VS0 = V_ACTIVE + V_FP;
  localparam int VS1 = VS0 + V_SYNC;
  localparam logic [ADDR_W-1:0] FRAME =
    ADDR_W'(H_ACTIVE * V_ACTIVE);

  if (longint'(2) * H_ACTIVE * V_ACTIVE >
      (longint'(1) << ADDR_W)) begin : g_size_chk
    $error("two frame banks do not fit in ADDR_W");
  end

  logic [HW-1:0]     h_q;
  logic [VW-1:0]     v_q;
  logic [31:0]       h_w;
  logic [31:0]       v_w;
  logic              run;
  logic              act;
  logic              wrap;
  logic              do_swap;
  logic [ADDR_W-1:0] ptr_q;
  logic [ADDR_W-1:0] hold_q;
  logic [ADDR_W-1:0] base_d;
  logic              bank_q;
  logic              pend_q;
  logic              ack_q;
  logic              de1_q;
  logic              hs1_q;
  logic              vs1_q;
  logic              fs1_q;
  logic              de_q;
  logic              hs_q;
  logic              vs_q;
  logic              fs_q;
  logic [PIX_W-1:0]  pix_q;

  assign h_w     = 32'(h_q);
  assign v_w     = 32'(v_q);
  assign run     = en & reset;
  assign act     = run && h_w < H_ACTIVE && v_w < V_ACTIVE;
  assign wrap    = run && h_w == HT - 1 && v_w == VT - 1;
  assign do_swap = wrap && (pend_q || swap_req);
  assign base_d  = (bank_q ^ do_swap) ? FRAME : '0;

  assign rd_en   = act;
  assign rd_addr = act ? ptr_q : hold_q;

  // ptr_q always points at the next pixel to fetch in the shown bank
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      h_q    <= '0;
      v_q    <= '0;
      ptr_q  <= '0;
      hold_q <= '0;
    end else begin
      hold_q <= rd_addr;
      if (!en) begin
        h_q   <= '0;
        v_q   <= '0;
        ptr_q <= bank_q ? FRAME : '0;
      end else begin
        if (h_w == HT - 1) begin
          h_q <= '0;
          v_q <= (v_w == VT - 1) ? '0 : v_q + 1'b1;
        end else begin
          h_q <= h_q + 1'b1;
        end
        if (wrap) begin
          ptr_q <= base_d;
        end else if (act) begin
          ptr_q <= ptr_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bank_q <= 1'b0;
      pend_q <= 1'b0;
      ack_q  <= 1'b0;
    end else begin
      ack_q <= do_swap;
      if (do_swap) begin
        bank_q <= ~bank_q;
        pend_q <= 1'b0;
      end else if (swap_req) begin
        pend_q <= 1'b1;
      end
    end
  end

  // stage 1 waits for RAM latency, stage 2 merges rd_data
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      de1_q <= 1'b0;
      hs1_q <= 1'b1;
      vs1_q <= 1'b1;
      fs1_q <= 1'b0;
      de_q  <= 1'b0;
      hs_q  <= 1'b1;
      vs_q  <= 1'b1;
      fs_q  <= 1'b0;
      pix_q <= '0;
    end else begin
      de1_q <= act;
      hs1_q <= !(run && h_w >= HS0 && h_w < HS1);
      vs1_q <= !(run && v_w >= VS0 && v_w < VS1);
      fs1_q <= run && h_w == 0 && v_w == 0;
      de_q  <= de1_q;
      hs_q  <= hs1_q;
      vs_q  <= vs1_q;
      fs_q  <= fs1_q;
      pix_q <= de1_q ? rd_data : '0;
    end
  end

  assign pix_out     = pix_q;
  assign de          = de_q;
  assign hsync       = hs_q;
  assign vsync       = vs_q;
  assign frame_start = fs_q;
  assign bank        = bank_q;
  assign swap_ack    = ack_q;

endmodule

// File: tb/tb_fb_scan_reader.sv
// tb_fb_scan_reader: raster/bank model compared every cycle,
// plus directed swap, enable-drop and reset scenarios.
module tb_fb_scan_reader;

  localparam int HA  = 4;
  localparam int HFP = 1;
  localparam int HSY = 1;
  localparam int HBP = 1;
  localparam int VA  = 3;
  localparam int VFP = 1;
  localparam int VSY = 1;
  localparam int VBP = 1;
  localparam int HT  = HA + HFP + HSY + HBP;
  localparam int VT  = VA + VFP + VSY + VBP;
  localparam int AW  = 8;

  typedef struct packed {
    logic       de;
    logic [7:0] pix;
    logic       hs;
    logic       vs;
    logic       fs;
  } o_t;

  localparam o_t IDLE = '{de: 1'b0, pix: 8'h00,
                          hs: 1'b1, vs: 1'b1, fs: 1'b0};

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          en = 1'b0;
  logic          swap_req = 1'b0;
  logic [7:0]    rd_data = 8'h00;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [7:0]    pix_out;
  logic          de;
  logic          hsync;
  logic          vsync;
  logic          frame_start;
  logic          bank;
  logic          swap_ack;

  fb_scan_reader #(
    .PIX_W(8), .ADDR_W(AW),
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP)
  ) dut (
    .clock(clock), .reset(reset), .en(en),
    .swap_req(swap_req), .rd_data(rd_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .pix_out(pix_out),
    .de(de), .hsync(hsync), .vsync(vsync),
    .frame_start(frame_start), .bank(bank),
    .swap_ack(swap_ack)
  );

  always #5 clock = ~clock;

  // RAM: word k holds k + 8'h10, one cycle read latency
  always @(posedge clock)
    if (rd_en) rd_data <= rd_addr + 8'h10;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  bit armed = 1'b0;

  int mh = 0, mv = 0, mbank = 0, mpend = 0, mack = 0;
  int last_addr = 0;
  o_t p1 = IDLE;
  o_t p2 = IDLE;

  logic       rec_rden [0:127];
  logic [7:0] rec_addr [0:127];
  logic [7:0] rec_pix  [0:127];
  logic       rec_de   [0:127];
  logic       rec_hs   [0:127];
  logic       rec_vs   [0:127];
  logic       rec_fs   [0:127];
  logic       rec_ack  [0:127];
  logic       rec_bank [0:127];

  task automatic chk(input string name,
                     input logic [31:0] got,
                     input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s cyc=%0d t=%0t got=%0h want=%0h",
               name, cyc, $time, got, want);
    end
  endtask

  // Reference: raster position, bank state and a 2-deep output delay
  always @(posedge clock or negedge reset) begin
    bit act;
    bit wrapc;
    int addr;
    o_t cur;
    if (!reset) begin
      mh = 0; mv = 0; mbank = 0; mpend = 0; mack = 0;
      last_addr = 0;
      p1 = IDLE;
      p2 = IDLE;
    end else begin
      act  = en && mh < HA && mv < VA;
      addr = mbank * HA * VA + mv * HA + mh;
      cur.de  = act;
      cur.pix = act ? 8'(addr + 16) : 8'h00;
      cur.hs  = !(en && mh >= HA + HFP && mh < HA + HFP + HSY);
      cur.vs  = !(en && mv >= VA + VFP && mv < VA + VFP + VSY);
      cur.fs  = en && mh == 0 && mv == 0;
      p2 = p1;
      p1 = cur;
      if (act) last_addr = addr;
      wrapc = en && mh == HT - 1 && mv == VT - 1;
      mack  = (wrapc && (mpend != 0 || swap_req)) ? 1 : 0;
      if (mack != 0) begin
        mbank = 1 - mbank;
        mpend = 0;
      end else if (swap_req) begin
        mpend = 1;
      end
      if (!en) begin
        mh = 0;
        mv = 0;
      end else begin
        mh++;
        if (mh == HT) begin
          mh = 0;
          mv = (mv + 1) % VT;
        end
      end
    end
  end

  always @(negedge clock) begin
    bit e_rden;
    int e_addr;
    if (armed) begin
      e_rden = reset && en && mh < HA && mv < VA;
      e_addr = e_rden ? mbank * HA * VA + mv * HA + mh : last_addr;
      chk("rd_en", 32'(rd_en), 32'(e_rden));
      chk("rd_addr", 32'(rd_addr), 32'(e_addr));
      chk("de", 32'(de), 32'(p2.de));
      chk("pix_out", 32'(pix_out), 32'(p2.pix));
      chk("hsync", 32'(hsync), 32'(p2.hs));
      chk("vsync", 32'(vsync), 32'(p2.vs));
      chk("frame_start", 32'(frame_start), 32'(p2.fs));
      chk("bank", 32'(bank), 32'(mbank));
      chk("swap_ack", 32'(swap_ack), 32'(mack));
      if (!reset) begin
        cyc = 0;
      end else begin
        if (cyc < 128) begin
          rec_rden[cyc] = rd_en;
          rec_addr[cyc] = rd_addr;
          rec_pix[cyc]  = pix_out;
          rec_de[cyc]   = de;
          rec_hs[cyc]   = hsync;
          rec_vs[cyc]   = vsync;
          rec_fs[cyc]   = frame_start;
          rec_ack[cyc]  = swap_ack;
          rec_bank[cyc] = bank;
        end
        cyc++;
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    int n;
    #1 reset = 1'b0;
    armed = 1'b1;
    repeat (3) tick();

    // frame timing, swap mid-frame, swap on wrap, double request
    en = 1'b1;
    reset = 1'b1;
    for (int c = 0; c < 131; c++) begin
      swap_req = (c == 20) || (c == 83) || (c == 90) || (c == 100);
      tick();
    end
    swap_req = 1'b0;
    chk("lit_rden0", 32'(rec_rden[0]), 32'd1);
    chk("lit_addr0", 32'(rec_addr[0]), 32'd0);
    chk("lit_addr3", 32'(rec_addr[3]), 32'd3);
    chk("lit_rden4", 32'(rec_rden[4]), 32'd0);
    chk("lit_de2", 32'(rec_de[2]), 32'd1);
    chk("lit_pix2", 32'(rec_pix[2]), 32'h10);
    chk("lit_pix5", 32'(rec_pix[5]), 32'h13);
    chk("lit_de6", 32'(rec_de[6]), 32'd0);
    chk("lit_fs2", 32'(rec_fs[2]), 32'd1);
    chk("lit_hs6", 32'(rec_hs[6]), 32'd1);
    chk("lit_hs7", 32'(rec_hs[7]), 32'd0);
    chk("lit_vs29", 32'(rec_vs[29]), 32'd1);
    chk("lit_vs30", 32'(rec_vs[30]), 32'd0);
    chk("lit_vs36", 32'(rec_vs[36]), 32'd0);
    chk("lit_vs37", 32'(rec_vs[37]), 32'd1);
    chk("lit_bank41", 32'(rec_bank[41]), 32'd0);
    chk("lit_ack42", 32'(rec_ack[42]), 32'd1);
    chk("lit_bank42", 32'(rec_bank[42]), 32'd1);
    chk("lit_addr42", 32'(rec_addr[42]), 32'd12);
    chk("lit_addr59", 32'(rec_addr[59]), 32'd23);
    chk("lit_pix44", 32'(rec_pix[44]), 32'h1C);
    chk("lit_fs44", 32'(rec_fs[44]), 32'd1);
    chk("lit_ack84", 32'(rec_ack[84]), 32'd1);
    chk("lit_bank84", 32'(rec_bank[84]), 32'd0);
    n = 0;
    for (int k = 85; k < 126; k++) n += int'(rec_ack[k]);
    chk("lit_noack_85_125", 32'(n), 32'd0);
    chk("lit_ack126", 32'(rec_ack[126]), 32'd1);
    chk("lit_bank126", 32'(rec_bank[126]), 32'd1);

    // enable dropped mid-frame while showing bank 1
    reset = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    for (int c = 0; c < 106; c++) begin
      en = !(c >= 57 && c <= 61);
      swap_req = (c == 5) || (c == 58);
      tick();
    end
    en = 1'b1;
    swap_req = 1'b0;
    chk("lit_en_rden57", 32'(rec_rden[57]), 32'd0);
    chk("lit_en_de58", 32'(rec_de[58]), 32'd1);
    chk("lit_en_de59", 32'(rec_de[59]), 32'd0);
    chk("lit_en_addr62", 32'(rec_addr[62]), 32'd12);
    chk("lit_en_bank62", 32'(rec_bank[62]), 32'd1);
    chk("lit_en_ack104", 32'(rec_ack[104]), 32'd1);
    chk("lit_en_bank104", 32'(rec_bank[104]), 32'd0);

    // reset mid-frame discards a pending swap
    reset = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    for (int c = 0; c < 30; c++) begin
      swap_req = (c == 10);
      tick();
    end
    swap_req = 1'b0;
    reset = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    repeat (50) tick();
    n = 0;
    for (int k = 0; k < 50; k++) n += int'(rec_ack[k]);
    chk("lit_rst_noack", 32'(n), 32'd0);
    chk("lit_rst_bank49", 32'(rec_bank[49]), 32'd0);
    chk("lit_rst_addr42", 32'(rec_addr[42]), 32'd0);

    // randomized enable, requests and occasional resets
    for (int i = 0; i < 3000; i++) begin
      en = $urandom_range(0, 15) != 0;
      swap_req = $urandom_range(0, 40) == 0;
      reset = $urandom_range(0, 700) != 0;
      tick();
    end
    reset = 1'b1;
    en = 1'b1;
    swap_req = 1'b0;
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
